// File: rtl/exe_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE bits per CALC cycle.
module exe_muldiv_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      tag_i,
    input  logic            kill_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      tag_o,
    output logic            busy_o
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST    = CW'(N - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   dvsr;

    logic              sgn1;
    logic              sgn2;
    logic              s1;
    logic              s2;
    logic              is_div;
    logic              div0;
    logic              ovf;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN-1:0]   special;

    logic [2*XLEN-1:0] mul_prod;
    logic [2*XLEN-1:0] mul_mc;
    logic [XLEN-1:0]   mul_mp;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN:0]     trial;
    logic              ge;
    logic [2*XLEN-1:0] p_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   fin_res;

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);

    // Request decode: operands become magnitudes, signs fixed up at the end.
    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        unique case (funct3_i)
            3'd1, 3'd4, 3'd6: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            3'd2:    sgn1 = 1'b1;
            default: ;
        endcase
        s1      = sgn1 & rs1_i[XLEN-1];
        s2      = sgn2 & rs2_i[XLEN-1];
        mag1    = s1 ? -rs1_i : rs1_i;
        mag2    = s2 ? -rs2_i : rs2_i;
        is_div  = funct3_i[2];
        div0    = is_div && (rs2_i == '0);
        ovf     = is_div && !funct3_i[0]
                  && (rs1_i == MIN_NEG) && (rs2_i == '1);
        special = '0;
        if (div0)
            special = funct3_i[1] ? rs1_i : '1;
        else if (ovf)
            special = funct3_i[1] ? '0 : rs1_i;
    end

    always_comb begin
        mul_prod = prod;
        mul_mc   = mcand;
        mul_mp   = mplier;
        div_rem  = rem;
        div_quo  = quo;
        trial    = '0;
        ge       = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mul_mp[0])
                mul_prod = mul_prod + mul_mc;
            mul_mc = mul_mc << 1;
            mul_mp = mul_mp >> 1;

            trial = {div_rem, div_quo[XLEN-1]};
            ge    = (trial >= {1'b0, dvsr});
            if (ge)
                div_rem = trial[XLEN-1:0] - dvsr;
            else
                div_rem = trial[XLEN-1:0];
            div_quo = {div_quo[XLEN-2:0], ge};
        end
    end

    // Sign fix and result select for the final CALC step.
    always_comb begin
        p_fix   = neg_q ? -mul_prod : mul_prod;
        q_fix   = neg_q ? -div_quo : div_quo;
        r_fix   = neg_r ? -div_rem : div_rem;
        fin_res = '0;
        unique case (1'b1)
            (op == 3'd0):            fin_res = p_fix[XLEN-1:0];
            (!op[2] && op != 3'd0):  fin_res = p_fix[2*XLEN-1:XLEN];
            (op[2] && !op[1]):       fin_res = q_fix;
            (op[2] && op[1]):        fin_res = r_fix;
            default:                 fin_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (kill_i) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        op     <= funct3_i;
                        tag_o  <= tag_i;
                        cnt    <= '0;
                        neg_q  <= s1 ^ s2;
                        neg_r  <= s1;
                        prod   <= '0;
                        mcand  <= {{XLEN{1'b0}}, mag1};
                        mplier <= mag2;
                        rem    <= '0;
                        quo    <= mag1;
                        dvsr   <= mag2;
                        if (div0 || ovf) begin
                            state    <= DONE;
                            result_o <= special;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prod   <= mul_prod;
                    mcand  <= mul_mc;
                    mplier <= mul_mp;
                    rem    <= div_rem;
                    quo    <= div_quo;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state    <= DONE;
                        result_o <= fin_res;
                    end
                end
                DONE: begin
                    if (out_ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_iter.sv
// Bench for exe_muldiv_iter: one instance at 1 bit/cycle, one at 4 bits/cycle.
// Table vectors, random ops against a reference model, and handshake corners.
module tb_exe_muldiv_iter;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid[2];
    logic        in_ready[2];
    logic        kill[2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic        busy[2];
    logic [2:0]  funct3[2];
    logic [31:0] rs1[2];
    logic [31:0] rs2[2];
    logic [31:0] result[2];
    logic [4:0]  tag_in[2];
    logic [4:0]  tag_out[2];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[21];

    always #5 clk = ~clk;

    exe_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .funct3_i(funct3[0]), .rs1_i(rs1[0]), .rs2_i(rs2[0]),
        .tag_i(tag_in[0]), .kill_i(kill[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .result_o(result[0]), .tag_o(tag_out[0]), .busy_o(busy[0])
    );

    exe_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .funct3_i(funct3[1]), .rs1_i(rs1[1]), .rs2_i(rs2[1]),
        .tag_i(tag_in[1]), .kill_i(kill[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .result_o(result[1]), .tag_o(tag_out[1]), .busy_o(busy[1])
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit is_special(logic [2:0] f, logic [31:0] a,
                                      logic [31:0] b);
        return f[2] && ((b == 32'd0) ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a,
                                          logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb_;
        longint      q;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        p   = '0;
        q   = 0;
        case (f)
            3'd0: begin p = sa * sb_; return p[31:0]; end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb_;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb_;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic wait_result(int w, int lat, string name);
        int   n  = 1;
        bit   bok = 1'b1;
        exp_t e;
        while (!out_valid[w] && n < 200) begin
            if (!busy[w]) bok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!busy[w]) bok = 1'b0;
        check({name, " latency"}, n, lat);
        check({name, " busy"}, {31'd0, bok}, 32'd1);
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " result"}, result[w], e.res);
            check({name, " tag"}, {27'd0, tag_out[w]}, {27'd0, e.tag});
        end
    endtask

    task automatic issue(int w, logic [2:0] f, logic [31:0] a,
                         logic [31:0] b, logic [4:0] t, string name);
        check({name, " in_ready"}, {31'd0, in_ready[w]}, 32'd1);
        in_valid[w]  = 1'b1;
        funct3[w]    = f;
        rs1[w]       = a;
        rs2[w]       = b;
        tag_in[w]    = t;
        out_ready[w] = 1'b0;
        @(negedge clk);
        in_valid[w] = 1'b0;
        funct3[w]   = 3'($urandom);
        rs1[w]      = $urandom;
        rs2[w]      = $urandom;
    endtask

    task automatic run_op(int w, logic [2:0] f, logic [31:0] a,
                          logic [31:0] b, logic [4:0] t,
                          logic [31:0] exp, string name);
        exp_t e;
        int   lat;
        lat   = is_special(f, a, b) ? 1 : ((w == 0) ? 33 : 9);
        e.res = exp;
        e.tag = t;
        sb.push_back(e);
        issue(w, f, a, b, t, name);
        wait_result(w, lat, name);
        out_ready[w] = 1'b1;
        @(negedge clk);
        out_ready[w] = 1'b0;
        check({name, " back to idle"},
              {29'd0, in_ready[w], out_valid[w], busy[w]}, 32'd4);
    endtask

    initial begin
        bit          bad;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl = '{
            '{3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB},
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF},
            '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF},
            '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14},
            '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2},
            '{3'd5, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF},
            '{3'd7, 32'd5,         32'd0,         5'd10, 32'd5},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0},
            '{3'd4, 32'hFFFF_FF9C, 32'd7,         5'd13, 32'hFFFF_FFF2},
            '{3'd6, 32'hFFFF_FF9C, 32'd7,         5'd14, 32'hFFFF_FFFE},
            '{3'd4, 32'd100,       32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFF2},
            '{3'd6, 32'd100,       32'hFFFF_FFF9, 5'd16, 32'd2},
            '{3'd6, 32'hFFFF_FFFB, 32'd0,         5'd17, 32'hFFFF_FFFB},
            '{3'd4, 32'h8000_0000, 32'd1,         5'd18, 32'h8000_0000},
            '{3'd0, 32'd12345,     32'd0,         5'd19, 32'd0},
            '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'd0},
            '{3'd3, 32'h0001_0000, 32'h0001_0000, 5'd21, 32'd1}
        };

        rst = 1'b1;
        for (int w = 0; w < 2; w++) begin
            in_valid[w]  = 1'b0;
            kill[w]      = 1'b0;
            out_ready[w] = 1'b0;
            funct3[w]    = 3'd0;
            rs1[w]       = 32'd0;
            rs2[w]       = 32'd0;
            tag_in[w]    = 5'd0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check("reset outputs",
                  {out_valid[w], busy[w], in_ready[w], tag_out[w]},
                  {24'd0, 8'b0010_0000});
            check("reset result", result[w], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 21; i++)
            run_op(0, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 21; i++)
            run_op(1, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp,
                   $sformatf("r4 vec%0d", i));

        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            run_op(0, rf, ra, rb, 5'(i), model(rf, ra, rb),
                   $sformatf("rand%0d", i));
            run_op(1, rf, ra, rb, 5'(i + 8), model(rf, ra, rb),
                   $sformatf("r4 rand%0d", i));
        end

        // Back-pressure: result held, new requests ignored.
        sb.push_back('{32'd1, 5'd9});
        issue(0, 3'd3, 32'h0001_0000, 32'h0001_0000, 5'd9, "bp");
        wait_result(0, 33, "bp");
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1;
            funct3[0]   = 3'd0;
            rs1[0]      = 32'd3;
            rs2[0]      = 32'd3;
            tag_in[0]   = 5'd1;
            @(negedge clk);
            if (result[0] !== 32'd1 || tag_out[0] !== 5'd9 ||
                in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1)
                bad = 1'b1;
        end
        check("bp hold", {31'd0, bad}, 32'd0);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        check("bp release",
              {29'd0, in_ready[0], out_valid[0], busy[0]}, 32'd4);

        // Kill on the fifth CALC cycle.
        issue(0, 3'd5, 32'd1000, 32'd3, 5'd4, "kill calc");
        repeat (4) @(negedge clk);
        check("kill pre busy", {31'd0, busy[0]}, 32'd1);
        kill[0] = 1'b1;
        @(negedge clk);
        kill[0] = 1'b0;
        check("kill calc state",
              {29'd0, in_ready[0], out_valid[0], busy[0]}, 32'd4);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) bad = 1'b1;
        end
        check("kill calc no result", {31'd0, bad}, 32'd0);

        // Kill wins over a simultaneous accept.
        in_valid[0] = 1'b1;
        funct3[0]   = 3'd0;
        rs1[0]      = 32'd2;
        rs2[0]      = 32'd2;
        kill[0]     = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        kill[0]     = 1'b0;
        check("kill accept", {29'd0, in_ready[0], out_valid[0], busy[0]},
              32'd4);

        // Kill wins over out_ready in DONE.
        issue(0, 3'd5, 32'd5, 32'd0, 5'd3, "kill done");
        check("kill done valid", {31'd0, out_valid[0]}, 32'd1);
        kill[0]      = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        kill[0]      = 1'b0;
        out_ready[0] = 1'b0;
        check("kill done state",
              {29'd0, in_ready[0], out_valid[0], busy[0]}, 32'd4);
        run_op(0, 3'd7, 32'd100, 32'd7, 5'd22, 32'd2, "after kill");

        // Reset in the middle of CALC.
        issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "rst calc");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst calc outputs",
              {out_valid[0], busy[0], in_ready[0], tag_out[0]},
              {24'd0, 8'b0010_0000});
        check("rst calc result", result[0], 32'd0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) bad = 1'b1;
        end
        check("rst calc no result", {31'd0, bad}, 32'd0);
        run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB,
               "after rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
